// File: rtl/std_reg_bank.sv
// Byte-maskable register bank with one write port, one registered read port and
// valid/done/err status. Optional macro STD_REG_BANK_BYPASS_EN forwards same-address write data to the read.
module std_reg_bank #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      in,
    input  logic [WIDTH/8-1:0]    byte_en,
    input  logic                  clear,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      out,
    output logic                  read_done,
    output logic                  done,
    output logic                  err,
    output logic [DEPTH-1:0]      valid
);

    localparam int NBYTES   = WIDTH / 8;
    localparam bit FULL_MAP = ((1 << ADDR_WIDTH) == DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range_p0;
    logic             rd_in_range_p0;
    logic             wr_accept_p0;
    logic             wr_oob_p0;
    logic             rd_accept_p0;
    logic             rd_oob_p0;
    logic [WIDTH-1:0] wr_old_p0;
    logic [WIDTH-1:0] wr_merged_p0;
    logic [WIDTH-1:0] rd_entry_p0;
    logic [WIDTH-1:0] rd_data_p0;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0]  old_word,
        input logic [WIDTH-1:0]  new_word,
        input logic [NBYTES-1:0] mask
    );
        logic [WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // A fully populated address space can never be out of range.
    generate
        if (FULL_MAP) begin : g_full_map
            assign wr_in_range_p0 = 1'b1;
            assign rd_in_range_p0 = 1'b1;
        end else begin : g_partial_map
            localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
            assign wr_in_range_p0 = ({1'b0, write_addr} < LIMIT);
            assign rd_in_range_p0 = ({1'b0, read_addr} < LIMIT);
        end
    endgenerate

    always_comb begin
        wr_accept_p0 = write_en & wr_in_range_p0 & ~clear;
        wr_oob_p0    = write_en & ~wr_in_range_p0 & ~clear;
        rd_accept_p0 = read_en & rd_in_range_p0;
        rd_oob_p0    = read_en & ~rd_in_range_p0;
    end

    always_comb begin
        wr_old_p0   = '0;
        rd_entry_p0 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (write_addr == ADDR_WIDTH'(k)) begin
                wr_old_p0 = mem[k];
            end
            if (read_addr == ADDR_WIDTH'(k)) begin
                rd_entry_p0 = mem[k];
            end
        end
        wr_merged_p0 = merge_bytes(wr_old_p0, in, byte_en);
    end

    always_comb begin
        rd_data_p0 = rd_entry_p0;
`ifdef STD_REG_BANK_BYPASS_EN
        if (wr_accept_p0 && (write_addr == read_addr)) begin
            rd_data_p0 = wr_merged_p0;
        end
`endif
    end

    // ---- p0 -> p1: storage, read register and status pulses ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            valid     <= '0;
            out       <= '0;
            done      <= 1'b0;
            read_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= wr_accept_p0;
            read_done <= rd_accept_p0;
            err       <= wr_oob_p0 | rd_oob_p0;
            if (rd_accept_p0) begin
                out <= rd_data_p0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (clear) begin
                    mem[k]   <= '0;
                    valid[k] <= 1'b0;
                end else if (wr_accept_p0 && (write_addr == ADDR_WIDTH'(k))) begin
                    mem[k]   <= wr_merged_p0;
                    valid[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_std_reg_bank.sv
// Bench for std_reg_bank (WIDTH=32, DEPTH=6): directed vector table, reset and sweep
// sequences, then random traffic against a behavioural model of the bank.
module tb_std_reg_bank;

    localparam int W  = 32;
    localparam int D  = 6;
    localparam int AW = 3;
`ifdef STD_REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_en = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [W-1:0]  din = '0;
    logic [3:0]    byte_en = '0;
    logic          clear = 1'b0;
    logic          read_en = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic [W-1:0]  dout;
    logic          read_done;
    logic          done;
    logic          err;
    logic [D-1:0]  valid;

    std_reg_bank #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
        .in(din), .byte_en(byte_en), .clear(clear), .read_en(read_en),
        .read_addr(read_addr), .out(dout), .read_done(read_done), .done(done),
        .err(err), .valid(valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [W-1:0] m_mem [D];
    logic [D-1:0] m_valid;
    logic [W-1:0] m_out;
    logic         m_rdone, m_done, m_err;

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  d;
        logic [3:0]    be;
        logic          clr;
        logic          re;
        logic [AW-1:0] ra;
        logic [W-1:0]  eout;
        logic          erd;
        logic          edone;
        logic          eerr;
        logic [D-1:0]  evalid;
    } vec_t;

    vec_t tbl [13];
    logic [W-1:0] sweep_vals [D];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_mem[k] = '0;
        m_valid = '0;
        m_out   = '0;
        m_rdone = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic logic [W-1:0] model_merge(input logic [W-1:0] old_w,
                                                 input logic [W-1:0] new_w,
                                                 input logic [3:0] be);
        logic [W-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Applies the bank's rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit w_ok;
        bit r_ok;
        w_ok    = write_en && !clear && (int'(write_addr) < D);
        r_ok    = read_en && (int'(read_addr) < D);
        m_done  = w_ok;
        m_rdone = r_ok;
        m_err   = (write_en && !clear && int'(write_addr) >= D) || (read_en && int'(read_addr) >= D);
        if (r_ok) begin
            if (BYP && w_ok && write_addr == read_addr)
                m_out = model_merge(m_mem[int'(write_addr)], din, byte_en);
            else
                m_out = m_mem[int'(read_addr)];
        end
        if (clear) begin
            for (int k = 0; k < D; k++) m_mem[k] = '0;
            m_valid = '0;
        end else if (w_ok) begin
            m_mem[int'(write_addr)] = model_merge(m_mem[int'(write_addr)], din, byte_en);
            m_valid[int'(write_addr)] = 1'b1;
        end
    endtask

    task automatic drive_edge(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] d,
                              input logic [3:0] be, input logic clr, input logic re,
                              input logic [AW-1:0] ra);
        write_en = we; write_addr = wa; din = d; byte_en = be;
        clear = clr; read_en = re; read_addr = ra;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " out"}, dout, m_out);
        chk({tag, " read_done"}, 32'(read_done), 32'(m_rdone));
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " err"}, 32'(err), 32'(m_err));
        chk({tag, " valid"}, 32'(valid), 32'(m_valid));
    endtask

    initial begin
        logic [W-1:0] same_out;
        same_out = BYP ? 32'h9 : 32'h5;
        tbl[0]  = '{"wr2_full", 1, 3'd2, 32'hAABBCCDD, 4'hF, 0, 0, 3'd0, 32'h0,        0, 1, 0, 6'b000100};
        tbl[1]  = '{"wr2_part", 1, 3'd2, 32'h11223344, 4'h5, 0, 0, 3'd0, 32'h0,        0, 1, 0, 6'b000100};
        tbl[2]  = '{"rd2",      0, 3'd0, 32'h0,        4'h0, 0, 1, 3'd2, 32'hAA22CC44, 1, 0, 0, 6'b000100};
        tbl[3]  = '{"idle",     0, 3'd0, 32'h0,        4'h0, 0, 0, 3'd2, 32'hAA22CC44, 0, 0, 0, 6'b000100};
        tbl[4]  = '{"wr7_oob",  1, 3'd7, 32'hFFFFFFFF, 4'hF, 0, 0, 3'd0, 32'hAA22CC44, 0, 0, 1, 6'b000100};
        tbl[5]  = '{"rd6_oob",  0, 3'd0, 32'h0,        4'h0, 0, 1, 3'd6, 32'hAA22CC44, 0, 0, 1, 6'b000100};
        tbl[6]  = '{"wr1_5",    1, 3'd1, 32'h5,        4'hF, 0, 0, 3'd0, 32'hAA22CC44, 0, 1, 0, 6'b000110};
        tbl[7]  = '{"wr1_rd1",  1, 3'd1, 32'h9,        4'hF, 0, 1, 3'd1, same_out,     1, 1, 0, 6'b000110};
        tbl[8]  = '{"wr0_clr",  1, 3'd0, 32'hDEADBEEF, 4'hF, 1, 0, 3'd0, same_out,     0, 0, 0, 6'b000000};
        tbl[9]  = '{"rd0",      0, 3'd0, 32'h0,        4'h0, 0, 1, 3'd0, 32'h0,        1, 0, 0, 6'b000000};
        tbl[10] = '{"wr3",      1, 3'd3, 32'h12345678, 4'hF, 0, 0, 3'd0, 32'h0,        0, 1, 0, 6'b001000};
        tbl[11] = '{"rd3_clr",  0, 3'd0, 32'h0,        4'h0, 1, 1, 3'd3, 32'h12345678, 1, 0, 0, 6'b000000};
        tbl[12] = '{"rd3",      0, 3'd0, 32'h0,        4'h0, 0, 1, 3'd3, 32'h0,        1, 0, 0, 6'b000000};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", dout, 32'h0);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset read_done", 32'(read_done), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive_edge(tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].be, tbl[i].clr, tbl[i].re, tbl[i].ra);
            chk({tbl[i].name, " out"}, dout, tbl[i].eout);
            chk({tbl[i].name, " read_done"}, 32'(read_done), 32'(tbl[i].erd));
            chk({tbl[i].name, " done"}, 32'(done), 32'(tbl[i].edone));
            chk({tbl[i].name, " err"}, 32'(err), 32'(tbl[i].eerr));
            chk({tbl[i].name, " valid"}, 32'(valid), 32'(tbl[i].evalid));
        end

        // Asynchronous reset mid-stream, with a write still presented on the inputs
        drive_edge(1, 3'd4, 32'hCAFEF00D, 4'hF, 0, 1, 3'd3);
        chk_model("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset out", dout, 32'h0);
        chk("async_reset valid", 32'(valid), 32'h0);
        chk("async_reset done", 32'(done), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model("in_reset");
        @(negedge clk);
        reset = 1'b1;
        drive_edge(1, 3'd5, 32'h0BADCAFE, 4'hF, 0, 0, 3'd0);
        chk_model("first_after_reset");
        chk("first_after_reset done", 32'(done), 32'h1);

        // Byte mask of zero still marks the entry written
        drive_edge(1, 3'd2, 32'hFFFFFFFF, 4'h0, 0, 0, 3'd0);
        chk_model("be_zero");
        drive_edge(0, 3'd0, 32'h0, 4'h0, 0, 1, 3'd2);
        chk("be_zero readback", dout, 32'h0);

        // Back-to-back writes to every entry, then a continuous read sweep
        for (int k = 0; k < D; k++) begin
            sweep_vals[k] = $urandom;
            drive_edge(1, AW'(k), sweep_vals[k], 4'hF, 0, 0, 3'd0);
            chk_model("b2b_write");
            chk("b2b done", 32'(done), 32'h1);
        end
        chk("all valid", 32'(valid), 32'h3F);
        for (int k = 0; k < D; k++) begin
            drive_edge(0, 3'd0, 32'h0, 4'h0, 0, 1, AW'(k));
            chk("sweep out", dout, sweep_vals[k]);
            chk("sweep read_done", 32'(read_done), 32'h1);
        end

        for (int n = 0; n < 400; n++) begin
            drive_edge(1'($urandom_range(1)), AW'($urandom_range(7)), $urandom,
                       4'($urandom_range(15)), ($urandom_range(15) == 0),
                       1'($urandom_range(1)), AW'($urandom_range(7)));
            chk_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/std_reg_bank.md
STD_REG_BANK -- requirements
Module: std_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning entry data width in bits; a legal value is a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries; a legal value is 2 to 256.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 3, meaning address width; a legal value satisfies 2**ADDR_WIDTH >= DEPTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port write_en, input, 1 bit: write request this cycle.
REQ-007 The block SHALL have port write_addr, input, ADDR_WIDTH bits: target entry.
REQ-008 The block SHALL have port in, input, WIDTH bits: write data.
REQ-009 The block SHALL have port byte_en, input, WIDTH/8 bits: per-byte write mask, bit i covering in[8i+7:8i].
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear of all entries.
REQ-011 The block SHALL have port read_en, input, 1 bit: read request this cycle.
REQ-012 The block SHALL have port read_addr, input, ADDR_WIDTH bits: entry to read.
REQ-013 The block SHALL have port out, output, WIDTH bits: registered read data.
REQ-014 The block SHALL have port read_done, output, 1 bit: single-cycle pulse marking out valid.
REQ-015 The block SHALL have port done, output, 1 bit: single-cycle pulse acknowledging an accepted write.
REQ-016 The block SHALL have port err, output, 1 bit: single-cycle pulse flagging an out-of-range access.
REQ-017 The block SHALL have port valid, output, DEPTH bits: bit k is 1 when entry k has been written since the last clear or reset.

Function
REQ-018 The block SHALL, on a write_en edge with write_addr < DEPTH and clear low, update only the bytes of the entry selected by byte_en, set valid[write_addr], and assert done for exactly the next cycle.
REQ-019 The block SHALL accept a write with byte_en all zero: entry data unchanged, valid bit set, done pulsed.
REQ-020 The block SHALL hold done low in any cycle following no accepted write, so back-to-back writes give done high on consecutive cycles.
REQ-021 The block SHALL, on a read_en edge with read_addr < DEPTH, load out with the entry contents and pulse read_done on the next cycle (latency 1); out holds its value while read_en is low.
REQ-022 The block SHALL, on a read or write whose address is >= DEPTH, leave all state and out unchanged, suppress done/read_done for that request, and pulse err for one cycle.
REQ-023 The block SHALL, when clear is high, zero all entries and all valid bits on that edge; a simultaneous write is dropped with done low and err low.
REQ-024 The block SHALL, for a simultaneous read and clear, return the pre-clear entry contents.
REQ-025 The block SHALL, for a simultaneous read and write to the same in-range address with clear low, return data per REQ-030.
REQ-026 The block SHALL, for a simultaneous read and write to different addresses, process both independently.

Reset
REQ-027 The block SHALL, while reset is low, asynchronously force all entries, valid, out, done, read_done and err to 0.
REQ-028 The block SHALL, after reset deasserts, honour the first request on the first following rising edge; a write in flight when reset asserts is lost, and no done pulse follows.

Configuration
REQ-029 The block SHALL provide the macro STD_REG_BANK_BYPASS_EN, which selects the read data returned when a read and a write target the same address on the same edge.
REQ-030 The block SHALL, for a same-address read and write with STD_REG_BANK_BYPASS_EN defined, load out with the post-write merged value (new bytes where byte_en is set, old elsewhere); with the macro undefined, it SHALL load out with the pre-write value.

Verification
REQ-031 The bench SHALL cover: reset low mid-stream -> out=0, valid=0, done=0 immediately, without waiting for clk.
REQ-032 The bench SHALL cover: WIDTH=32; write addr 2, in=0xAABBCCDD, byte_en=4'b1111; then write addr 2, in=0x11223344, byte_en=4'b0101; then read addr 2 -> out=0xAA22CC44, read_done one cycle after read_en, done pulses on two consecutive cycles.
REQ-033 The bench SHALL cover: DEPTH=6, write addr 7 -> err pulse, done=0, valid unchanged; read addr 6 -> err pulse, out unchanged.
REQ-034 The bench SHALL cover: entry 1=0x5, then same-cycle write addr 1 in=0x9 full mask plus read addr 1 -> out=0x9 with the macro defined, out=0x5 with it undefined.
REQ-035 The bench SHALL cover: write addr 0 and clear on the same edge -> entry 0=0, valid=0, done=0; the next read of addr 0 -> out=0.
REQ-036 The bench SHALL cover: writes to all DEPTH entries back-to-back -> valid all ones, and a read sweep returns each value in order with read_done held high.
